// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one runtime-configurable LFSR among NUM_REQ requesters.
// Each grant loads taps/seed into the LFSR, gathers the requested bits, returns them packed.
module lfsr_sched #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 32,
  parameter int LW      = $clog2(MAX_LEN + 1),
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*N-1:0] req_taps_i,
  input  logic [NUM_REQ*N-1:0] req_seed_i,
  input  logic [NUM_REQ*LW-1:0] req_len_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [MAX_LEN-1:0]   rsp_data_o,
  output logic                 busy_o,
  output logic                 lfsr_load_config_o,
  output logic [N-1:0]         lfsr_taps_o,
  output logic [N-1:0]         lfsr_start_value_o,
  input  logic                 lfsr_data_i,
  input  logic                 lfsr_valid_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [N-1:0]       taps_q, taps_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;

  logic [N-1:0]  taps_arr [NUM_REQ];
  logic [N-1:0]  seed_arr [NUM_REQ];
  logic [LW-1:0] len_arr  [NUM_REQ];

  // Requests are rotated so that position 0 is rr_ptr; the first set bit then
  // gives the offset from the pointer, and seen[] doubles as the "any request" flag.
  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] first_oh;
  logic [NUM_REQ:0]   seen;
  logic [IDW-1:0]     off_chain [NUM_REQ+1];

  assign req_rot      = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
  assign seen[0]      = 1'b0;
  assign off_chain[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign taps_arr[gi]      = req_taps_i[gi*N +: N];
      assign seed_arr[gi]      = req_seed_i[gi*N +: N];
      assign len_arr[gi]       = req_len_i[gi*LW +: LW];
      assign first_oh[gi]      = req_rot[gi] & ~seen[gi];
      assign seen[gi+1]        = seen[gi] | req_rot[gi];
      assign off_chain[gi+1]   = off_chain[gi] | (first_oh[gi] ? IDW'(gi) : '0);
    end
  endgenerate

  logic [IDW:0]   gnt_sum;
  logic [IDW-1:0] gnt_idx;
  logic           grant_en;
  logic [LW-1:0]  len_sel;
  logic [LW-1:0]  len_clamped;
  logic [LW-1:0]  cnt_inc;

  assign gnt_sum  = {1'b0, rr_ptr_q} + {1'b0, off_chain[NUM_REQ]};
  assign gnt_idx  = IDW'((gnt_sum >= (IDW+1)'(NUM_REQ)) ? gnt_sum - (IDW+1)'(NUM_REQ) : gnt_sum);
  // Gated by reset so the accept pulse is also silent while reset is held.
  assign grant_en = reset_ni && (state_q == ST_IDLE) && seen[NUM_REQ];

  assign len_sel     = len_arr[gnt_idx];
  assign len_clamped = (len_sel > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_sel;
  assign cnt_inc     = cnt_q + LW'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    taps_d   = taps_q;
    seed_d   = seed_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          taps_d   = taps_arr[gnt_idx];
          seed_d   = seed_arr[gnt_idx];
          len_d    = len_clamped;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = (len_clamped == '0) ? ST_OUT : ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        // The LFSR shows valid low in the first RUN cycle, so stale data never lands here.
        if (lfsr_valid_i) begin
          acc_d = acc_q | (MAX_LEN'(lfsr_data_i) << cnt_q);
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      taps_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      taps_q   <= taps_d;
      seed_q   <= seed_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign req_ready_o        = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rsp_valid_o        = (state_q == ST_OUT);
  assign rsp_id_o           = id_q;
  assign rsp_data_o         = acc_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign lfsr_load_config_o = (state_q == ST_LOAD);
  assign lfsr_taps_o        = taps_q;
  assign lfsr_start_value_o = seed_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// Scoreboard bench for lfsr_sched: a bench-side LFSR drives the data port, a
// grant predictor pushes expected responses, a monitor pops and compares them.
module tb_lfsr_sched;
  localparam int N = 8, NR = 4, ML = 32, LW = 6, IDW = 2;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*N-1:0] req_taps = '0;
  logic [NR*N-1:0] req_seed = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic [NR-1:0]   req_ready_o;
  logic            rsp_valid_o;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id_o;
  logic [ML-1:0]   rsp_data_o;
  logic            busy_o, lfsr_load_config_o;
  logic [N-1:0]    lfsr_taps_o, lfsr_start_value_o;
  logic            lfsr_data_i, lfsr_valid_i;

  lfsr_sched #(.N(N), .NUM_REQ(NR), .MAX_LEN(ML)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid), .req_taps_i(req_taps), .req_seed_i(req_seed), .req_len_i(req_len),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o),
    .lfsr_load_config_o(lfsr_load_config_o), .lfsr_taps_o(lfsr_taps_o),
    .lfsr_start_value_o(lfsr_start_value_o),
    .lfsr_data_i(lfsr_data_i), .lfsr_valid_i(lfsr_valid_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Bench-side LFSR: loads the seed, shows valid low for one cycle, then emits
  // state[0] each valid cycle and advances only when not stalled.
  logic [N-1:0] lf_st = '0;
  logic         lf_v = 1'b0;
  logic         stall = 1'b0;
  always @(posedge clk_i) begin
    if (lfsr_load_config_o) begin
      lf_st <= lfsr_start_value_o;
      lf_v  <= 1'b0;
    end else if (!lf_v) begin
      lf_v <= 1'b1;
    end else if (!stall) begin
      lf_st <= {^(lf_st & lfsr_taps_o), lf_st[N-1:1]};
    end
  end
  assign lfsr_data_i  = lf_st[0];
  assign lfsr_valid_i = lf_v & ~stall;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: packed word of the first len output bits of the LFSR sequence.
  function automatic logic [31:0] golden(input int taps, input int seed, input int len);
    logic [31:0] r;
    int st;
    r  = '0;
    st = seed;
    for (int k = 0; k < len; k++) begin
      r[k] = 1'(st % 2);
      st   = (st >> 1) + 128 * ($countones(st & taps) % 2);
    end
    return r;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] data;
    int          lat;
    int          gcyc;
  } exp_t;

  exp_t sbq[$];
  int   dut_gnt_log[$];
  bit   model_free = 1'b1;
  int   model_rr = 0;
  bit   out_active = 1'b0;
  exp_t cur;
  int   load_cyc = -10;
  int   load_taps, load_seed;
  int   extra_lat = 0;
  bit   lat_check = 1'b1;
  int   n_rsp = 0;

  always @(negedge clk_i) begin
    int   eg, t, s, l, lc;
    exp_t e;
    if (!reset_ni) begin
      sbq.delete();
      model_free = 1'b1;
      model_rr   = 0;
      out_active = 1'b0;
      load_cyc   = -10;
    end else begin
      eg = -1;
      if (model_free)
        for (int i = 0; i < NR; i++)
          if (eg < 0 && req_valid[(model_rr + i) % NR]) eg = (model_rr + i) % NR;
      for (int i = 0; i < NR; i++) if (req_ready_o[i]) dut_gnt_log.push_back(i);
      if (eg >= 0 || req_ready_o != '0) begin
        check("grant", 64'(req_ready_o), (eg >= 0) ? 64'(1 << eg) : 64'd0);
        if (eg >= 0) begin
          t  = int'(req_taps[eg*N +: N]);
          s  = int'(req_seed[eg*N +: N]);
          l  = int'(req_len[eg*LW +: LW]);
          lc = (l > ML) ? ML : l;
          e.id   = eg;
          e.data = golden(t, s, lc);
          e.lat  = lat_check ? ((lc == 0) ? 1 : 3 + lc + extra_lat) : -1;
          e.gcyc = cyc;
          sbq.push_back(e);
          model_rr   = (eg + 1) % NR;
          model_free = 1'b0;
          if (lc > 0) begin
            load_cyc  = cyc + 1;
            load_taps = t;
            load_seed = s;
          end
        end
      end
      if (lfsr_load_config_o || cyc == load_cyc) begin
        check("load_pulse", 64'(lfsr_load_config_o), 64'(cyc == load_cyc));
        if (cyc == load_cyc) begin
          check("load_taps", 64'(lfsr_taps_o), 64'(load_taps));
          check("load_seed", 64'(lfsr_start_value_o), 64'(load_seed));
        end
      end
      if (rsp_valid_o) begin
        if (!out_active) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response (cycle %0d)",
                     rsp_id_o, rsp_data_o, cyc);
          end else begin
            cur = sbq.pop_front();
            out_active = 1'b1;
            if (cur.lat >= 0) check("rsp_latency", 64'(cyc - cur.gcyc), 64'(cur.lat));
          end
        end
        if (out_active) begin
          check("rsp_id", 64'(rsp_id_o), 64'(cur.id));
          check("rsp_data", 64'(rsp_data_o), 64'(cur.data));
          if (rsp_ready) begin
            $display("rsp #%0d: id %0d data 0x%08h (cycle %0d)", n_rsp, rsp_id_o, rsp_data_o, cyc);
            n_rsp++;
            out_active = 1'b0;
            model_free = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int k, input int t, input int s, input int l);
    req_taps[k*N +: N]   = N'(t);
    req_seed[k*N +: N]   = N'(s);
    req_len[k*LW +: LW]  = LW'(l);
    req_valid[k]         = 1'b1;
  endtask

  task automatic wait_grant(input int k);
    int n = 0;
    while (n < 400) begin
      @(negedge clk_i);
      if (req_ready_o[k]) break;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d got no grant, expected one within 400 cycles", k);
    end
    step();
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 400) begin
      @(negedge clk_i);
      if (sbq.size() == 0 && !out_active && !busy_o) break;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size() + int'(out_active));
    end
  endtask

  task automatic wait_log(input int cnt);
    int n = 0;
    while (dut_gnt_log.size() < cnt && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout: %0d grants seen, expected %0d", dut_gnt_log.size(), cnt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id_o), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_load"}, 64'(lfsr_load_config_o), 64'd0);
    check({tag, "_taps"}, 64'(lfsr_taps_o), 64'd0);
    check({tag, "_seed"}, 64'(lfsr_start_value_o), 64'd0);
  endtask

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_exp[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    logic [NR-1:0] gv;

    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    step();
    reset_ni = 1'b1;

    // Round-robin with all four requesters, then with requester 1 dropped.
    step();
    dut_gnt_log.delete();
    for (int k = 0; k < NR; k++) issue(k, 8'h8E + k, k + 1, 4);
    wait_log(5);
    step();
    req_valid[1] = 1'b0;
    wait_log(9);
    step();
    req_valid = '0;
    drain();
    for (int i = 0; i < 9; i++) check("rr_order", 64'(dut_gnt_log[i]), 64'(rr_exp[i]));

    // Single request with latency 11.
    step();
    issue(0, 8'h03, 8'h01, 8);
    wait_grant(0);
    drain();

    // Back-pressure: response held 20 cycles while requester 2 waits.
    step();
    rsp_ready = 1'b0;
    issue(1, 8'hB4, 8'h5A, 8);
    issue(2, 8'h1D, 8'hC3, 4);
    wait_grant(1);
    begin
      int n = 0;
      while (!rsp_valid_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      check("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
    end
    repeat (20) @(posedge clk_i);
    #1 rsp_ready = 1'b1;
    wait_grant(2);
    drain();

    // Three LFSR stall cycles mid-run add three cycles of latency.
    step();
    extra_lat = 3;
    issue(1, 8'hE1, 8'h77, 8);
    wait_grant(1);
    extra_lat = 0;
    repeat (3) @(posedge clk_i);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 stall = 1'b0;
    drain();

    // Length boundaries and seed 0.
    step();
    issue(3, 8'h5F, 8'h99, 0);
    wait_grant(3);
    drain();
    step();
    issue(0, 8'hB8, 8'hA5, 32);
    wait_grant(0);
    drain();
    step();
    issue(1, 8'h71, 8'h3C, 40);
    wait_grant(1);
    drain();
    step();
    issue(2, 8'hFF, 8'h00, 16);
    wait_grant(2);
    drain();

    // Asynchronous reset in the middle of a run.
    step();
    issue(2, 8'hB8, 8'hE7, 16);
    wait_grant(2);
    repeat (5) @(posedge clk_i);
    #3 reset_ni = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    dut_gnt_log.delete();
    issue(3, 8'h2D, 8'h11, 5);
    issue(0, 8'h4B, 8'h22, 6);
    wait_grant(0);
    check("post_reset_first_grant", 64'(dut_gnt_log[0]), 64'd0);
    wait_grant(3);
    drain();

    // Randomized traffic with random back-pressure and LFSR stalls.
    lat_check = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      gv = req_ready_o;
      step();
      for (int k = 0; k < NR; k++) begin
        if (gv[k] || !req_valid[k]) begin
          if (gv[k] || $urandom_range(0, 3) == 0) begin
            req_taps[k*N +: N]  = N'($urandom_range(0, 255));
            req_seed[k*N +: N]  = N'($urandom_range(0, 255));
            req_len[k*LW +: LW] = LW'($urandom_range(0, 40));
            req_valid[k]        = gv[k] ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 5) == 0);
    end
    req_valid = '0;
    stall     = 1'b0;
    rsp_ready = 1'b1;
    drain();

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
